// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and the per-entry payload type.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE         = 16;
    localparam int unsigned ROB_COMMIT_WIDTH = 2;
    localparam int unsigned ROB_DATA_W       = 64;
    localparam int unsigned ROB_RD_W         = 5;

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  mispredict;
        logic [ROB_RD_W-1:0]   rd;
        logic [ROB_DATA_W-1:0] pc;
        logic [ROB_DATA_W-1:0] value;
        logic [ROB_DATA_W-1:0] target;
    } rob_entry;

endpackage

// File: rtl/reorder_buffer_commit_select.sv
// In-order retirement scan: picks up to COMMIT_WIDTH consecutive finished
// entries starting at head, stopping after the first mispredicted one.
module rob_commit_select #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned TAG_W        = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]              done,
    input  logic [DEPTH-1:0]              mispredict,
    input  logic [TAG_W-1:0]              head,
    output logic [COMMIT_WIDTH-1:0]       slot_valid,
    output logic [COMMIT_WIDTH*TAG_W-1:0] slot_idx
);

    logic [TAG_W-1:0] idx;
    logic             chain;

    // Index arithmetic wraps naturally because DEPTH is a power of two
    always_comb begin
        slot_valid = '0;
        slot_idx   = '0;
        idx        = head;
        chain      = 1'b1;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            idx                        = head + TAG_W'(i);
            slot_idx[i*TAG_W +: TAG_W] = idx;
            slot_valid[i]              = chain && done[idx];
            chain                      = slot_valid[i] && !mispredict[idx];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer with in-order multi-wide commit and mispredict flush.
// Define ROB_CDB_BYPASS_EN to forward a same-cycle CDB result to the rd ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = ROB_SIZE,
    parameter int unsigned COMMIT_WIDTH = ROB_COMMIT_WIDTH,
    parameter int unsigned DATA_W       = ROB_DATA_W,
    parameter int unsigned TAG_W        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    input  logic [ROB_RD_W-1:0]          alloc_rd,
    input  logic [DATA_W-1:0]            alloc_pc,
    output logic                         alloc_ready,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_value,
    input  logic                         cdb_mispredict,
    input  logic [DATA_W-1:0]            cdb_target,
    input  logic [TAG_W-1:0]             rd_tag1,
    input  logic [TAG_W-1:0]             rd_tag2,
    output logic                         rd_ready1,
    output logic                         rd_ready2,
    output logic [DATA_W-1:0]            rd_value1,
    output logic [DATA_W-1:0]            rd_value2,
    output logic [COMMIT_WIDTH-1:0]      commit_valid,
    output logic [COMMIT_WIDTH*ROB_RD_W-1:0] commit_rd,
    output logic [COMMIT_WIDTH*DATA_W-1:0]   commit_value,
    output logic                         flush,
    output logic [DATA_W-1:0]            flush_pc,
    output logic [TAG_W:0]               count,
    output logic                         empty
);

    localparam int unsigned PTR_W = TAG_W + 1;

    rob_entry               entries [DEPTH];
    logic [PTR_W-1:0]       head_ptr;
    logic [PTR_W-1:0]       tail_ptr;
    logic [DEPTH-1:0]       done_vec;
    logic [DEPTH-1:0]       mispred_vec;
    logic [COMMIT_WIDTH-1:0]       slot_valid;
    logic [COMMIT_WIDTH*TAG_W-1:0] slot_idx;
    logic [TAG_W-1:0]       sidx;
    logic [PTR_W-1:0]       retire_cnt;
    logic                   alloc_fire;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            done_vec[i]    = entries[i].busy && entries[i].done;
            mispred_vec[i] = entries[i].mispredict;
        end
    end

    rob_commit_select #(
        .DEPTH        (DEPTH),
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .TAG_W        (TAG_W)
    ) u_commit_select (
        .done       (done_vec),
        .mispredict (mispred_vec),
        .head       (head_ptr[TAG_W-1:0]),
        .slot_valid (slot_valid),
        .slot_idx   (slot_idx)
    );

    // Commit outputs; a mispredicting slot is always the last valid one
    always_comb begin
        commit_valid = '0;
        commit_rd    = '0;
        commit_value = '0;
        flush        = 1'b0;
        flush_pc     = '0;
        retire_cnt   = '0;
        sidx         = '0;
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            sidx = slot_idx[i*TAG_W +: TAG_W];
            if (slot_valid[i] && !reset) begin
                commit_valid[i]                     = 1'b1;
                commit_rd[i*ROB_RD_W +: ROB_RD_W]   = entries[sidx].rd;
                commit_value[i*DATA_W +: DATA_W]    = DATA_W'(entries[sidx].value);
                retire_cnt                          = retire_cnt + PTR_W'(1);
                if (entries[sidx].mispredict) begin
                    flush    = 1'b1;
                    flush_pc = DATA_W'(entries[sidx].target);
                end
            end
        end
    end

    assign count       = tail_ptr - head_ptr;
    assign alloc_ready = reset || ((count < PTR_W'(DEPTH)) && !flush);
    assign alloc_tag   = reset ? '0 : tail_ptr[TAG_W-1:0];
    assign empty       = reset || (count == '0);
    assign alloc_fire  = alloc_valid && alloc_ready && !reset;

    // Operand lookup, optionally forwarding the CDB result in the same cycle
    always_comb begin
        rd_ready1 = 1'b0;
        rd_value1 = '0;
        rd_ready2 = 1'b0;
        rd_value2 = '0;
        if (!reset) begin
            if (entries[rd_tag1].busy) begin
                rd_ready1 = entries[rd_tag1].done;
                rd_value1 = DATA_W'(entries[rd_tag1].value);
            end
            if (entries[rd_tag2].busy) begin
                rd_ready2 = entries[rd_tag2].done;
                rd_value2 = DATA_W'(entries[rd_tag2].value);
            end
`ifdef ROB_CDB_BYPASS_EN
            if (cdb_valid && (cdb_tag == rd_tag1) && entries[rd_tag1].busy) begin
                rd_ready1 = 1'b1;
                rd_value1 = cdb_value;
            end
            if (cdb_valid && (cdb_tag == rd_tag2) && entries[rd_tag2].busy) begin
                rd_ready2 = 1'b1;
                rd_value2 = cdb_value;
            end
`endif
        end
    end

    // Retire clears come after the CDB write so a retiring slot ends up free
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i].busy       <= 1'b0;
                entries[i].done       <= 1'b0;
                entries[i].mispredict <= 1'b0;
            end
            if (reset) begin
                head_ptr <= '0;
                tail_ptr <= '0;
            end else begin
                head_ptr <= tail_ptr;
            end
        end else begin
            if (cdb_valid && entries[cdb_tag].busy) begin
                entries[cdb_tag].done       <= 1'b1;
                entries[cdb_tag].value      <= ROB_DATA_W'(cdb_value);
                entries[cdb_tag].mispredict <= cdb_mispredict;
                entries[cdb_tag].target     <= ROB_DATA_W'(cdb_target);
            end
            for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
                if (commit_valid[i]) begin
                    entries[slot_idx[i*TAG_W +: TAG_W]].busy       <= 1'b0;
                    entries[slot_idx[i*TAG_W +: TAG_W]].done       <= 1'b0;
                    entries[slot_idx[i*TAG_W +: TAG_W]].mispredict <= 1'b0;
                end
            end
            if (alloc_fire) begin
                entries[tail_ptr[TAG_W-1:0]] <= '{busy: 1'b1, done: 1'b0, mispredict: 1'b0,
                                                   rd: alloc_rd, pc: ROB_DATA_W'(alloc_pc),
                                                   value: '0, target: '0};
            end
            head_ptr <= head_ptr + retire_cnt;
            tail_ptr <= tail_ptr + PTR_W'(alloc_fire);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a random
// alloc/writeback phase, with commits checked against an in-order scoreboard.
module tb_reorder_buffer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CW     = 2;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned RD_W   = 5;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   alloc_valid;
    logic [RD_W-1:0]        alloc_rd;
    logic [DATA_W-1:0]      alloc_pc;
    logic                   alloc_ready;
    logic [TAG_W-1:0]       alloc_tag;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_value;
    logic                   cdb_mispredict;
    logic [DATA_W-1:0]      cdb_target;
    logic [TAG_W-1:0]       rd_tag1;
    logic [TAG_W-1:0]       rd_tag2;
    logic                   rd_ready1;
    logic                   rd_ready2;
    logic [DATA_W-1:0]      rd_value1;
    logic [DATA_W-1:0]      rd_value2;
    logic [CW-1:0]          commit_valid;
    logic [CW*RD_W-1:0]     commit_rd;
    logic [CW*DATA_W-1:0]   commit_value;
    logic                   flush;
    logic [DATA_W-1:0]      flush_pc;
    logic [TAG_W:0]         count;
    logic                   empty;

    always #5 clk = ~clk;

    reorder_buffer #(
        .DEPTH(DEPTH), .COMMIT_WIDTH(CW), .DATA_W(DATA_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2),
        .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
        .rd_value1(rd_value1), .rd_value2(rd_value2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .flush(flush), .flush_pc(flush_pc), .count(count), .empty(empty)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [RD_W-1:0]  rd;
    } sb_item_t;

    sb_item_t         sb [$];
    logic [63:0]      exp_val [DEPTH];
    logic [TAG_W-1:0] model_tail;
    logic [TAG_W-1:0] pending [$];
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard: occupancy, in-order commits, allocation tags
    task automatic monitor();
        sb_item_t it;
        if (reset) begin
            sb.delete();
            model_tail = '0;
            return;
        end
        check("count_vs_model", 64'(count), 64'(sb.size()));
        for (int i = 0; i < int'(CW); i++) begin
            if (commit_valid[i]) begin
                if (sb.size() == 0) begin
                    check("commit_unexpected", 64'(commit_valid[i]), 64'(0));
                end else begin
                    it = sb.pop_front();
                    check("commit_rd", 64'(commit_rd[i*RD_W +: RD_W]), 64'(it.rd));
                    check("commit_value", commit_value[i*DATA_W +: DATA_W], exp_val[it.tag]);
                end
            end
        end
        if (flush) begin
            sb.delete();
        end else if (alloc_valid && alloc_ready) begin
            check("alloc_tag", 64'(alloc_tag), 64'(model_tail));
            sb.push_back('{tag: model_tail, rd: alloc_rd});
            model_tail = TAG_W'(model_tail + 1'b1);
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor();
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        alloc_valid    = 1'b0;
        alloc_rd       = '0;
        alloc_pc       = '0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_value      = '0;
        cdb_mispredict = 1'b0;
        cdb_target     = '0;
    endtask

    task automatic alloc(input logic [RD_W-1:0] rd);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_pc    = {$urandom, $urandom};
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [63:0] v,
                       input logic mp, input logic [63:0] tgt);
        cdb_valid      = 1'b1;
        cdb_tag        = t;
        cdb_value      = v;
        cdb_mispredict = mp;
        cdb_target     = tgt;
        exp_val[t]     = v;
    endtask

    task automatic do_reset();
        next_cycle();
        reset   = 1'b1;
        rd_tag1 = 4'd1;
        rd_tag2 = 4'd0;
        @(negedge clk);
        check("rst_commit_valid", 64'(commit_valid), 64'(0));
        check("rst_flush", 64'(flush), 64'(0));
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_alloc_tag", 64'(alloc_tag), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_rd_ready1", 64'(rd_ready1), 64'(0));
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_count", 64'(count), 64'(0));
        check("post_rst_empty", 64'(empty), 64'(1));
        check("post_rst_ready", 64'(alloc_ready), 64'(1));
        check("post_rst_tag", 64'(alloc_tag), 64'(0));
    endtask

    task automatic wait_empty(input int budget);
        for (int n = 0; n < budget; n++) begin
            next_cycle();
            @(negedge clk);
            if (empty) break;
        end
        check("drain_empty", 64'(empty), 64'(1));
    endtask

    initial begin
        logic [TAG_W-1:0] t;
        int               k;
        reset = 1'b1;
        alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target = '0;
        rd_tag1 = '0; rd_tag2 = '0;
        for (int i = 0; i < int'(DEPTH); i++) exp_val[i] = '0;

        // Fill the buffer, then retire the head while full and wrap the tail
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            next_cycle();
            alloc(RD_W'(i + 1));
            @(negedge clk);
            check("fill_tag", 64'(alloc_tag), 64'(i));
            check("fill_ready", 64'(alloc_ready), 64'(1));
        end
        next_cycle();
        alloc(5'd20);
        @(negedge clk);
        check("full_count", 64'(count), 64'(16));
        check("full_ready", 64'(alloc_ready), 64'(0));
        next_cycle();
        cdb(4'd0, 64'hC0DE_0000, 1'b0, 64'h0);
        next_cycle();
        alloc(5'd21);
        @(negedge clk);
        check("full_commit_valid", 64'(commit_valid), 64'(2'b01));
        check("full_commit_ready", 64'(alloc_ready), 64'(0));
        next_cycle();
        alloc(5'd22);
        @(negedge clk);
        check("wrap_ready", 64'(alloc_ready), 64'(1));
        check("wrap_tag", 64'(alloc_tag), 64'(0));
        check("wrap_count", 64'(count), 64'(15));
        for (int i = 1; i < int'(DEPTH); i++) begin
            next_cycle();
            cdb(TAG_W'(i), 64'h1000 + 64'(i), 1'b0, 64'h0);
        end
        next_cycle();
        cdb(4'd0, 64'hFEED, 1'b0, 64'h0);
        wait_empty(40);

        // Out-of-order completion, two-wide commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            alloc(RD_W'(i + 3));
        end
        next_cycle();
        cdb(4'd1, 64'hAA, 1'b0, 64'h0);
        next_cycle();
        cdb(4'd0, 64'h55, 1'b0, 64'h0);
        @(negedge clk);
        check("tag1_only_no_commit", 64'(commit_valid), 64'(0));
        next_cycle();
        @(negedge clk);
        check("pair_commit_valid", 64'(commit_valid), 64'(2'b11));
        check("pair_slot0_value", commit_value[0 +: DATA_W], 64'h55);
        check("pair_slot1_value", commit_value[DATA_W +: DATA_W], 64'hAA);
        check("pair_slot0_rd", 64'(commit_rd[0 +: RD_W]), 64'(3));
        check("pair_slot1_rd", 64'(commit_rd[RD_W +: RD_W]), 64'(4));
        next_cycle();
        @(negedge clk);
        check("pair_count_after", 64'(count), 64'(1));
        check("pair_tail_tag", 64'(alloc_tag), 64'(3));
        cdb(4'd2, 64'h77, 1'b0, 64'h0);
        wait_empty(10);

        // Mispredict at the head flushes everything younger
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            alloc(RD_W'(i + 8));
        end
        next_cycle();
        cdb(4'd1, 64'h11, 1'b0, 64'h0);
        next_cycle();
        cdb(4'd0, 64'h22, 1'b1, 64'h8000_0100);
        next_cycle();
        alloc(5'd9);
        @(negedge clk);
        check("mp_commit_valid", 64'(commit_valid), 64'(2'b01));
        check("mp_flush", 64'(flush), 64'(1));
        check("mp_flush_pc", flush_pc, 64'h8000_0100);
        check("mp_alloc_ready", 64'(alloc_ready), 64'(0));
        next_cycle();
        @(negedge clk);
        check("mp_count", 64'(count), 64'(0));
        check("mp_empty", 64'(empty), 64'(1));
        check("mp_flush_after", 64'(flush), 64'(0));
        check("mp_tag_after", 64'(alloc_tag), 64'(4));

        // Operand lookup and CDB visibility timing
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            alloc(RD_W'(i + 12));
        end
        next_cycle();
        cdb(4'd3, 64'h1234, 1'b0, 64'h0);
        rd_tag1 = 4'd3;
        rd_tag2 = 4'd2;
        @(negedge clk);
        check("byp_ready1", 64'(rd_ready1), 64'(BYPASS));
        check("byp_value1", rd_value1, BYPASS ? 64'h1234 : 64'h0);
        check("busy_not_done_ready", 64'(rd_ready2), 64'(0));
        check("busy_not_done_value", rd_value2, 64'h0);
        next_cycle();
        rd_tag2 = 4'd6;
        cdb(4'd6, 64'h777, 1'b0, 64'h0);
        @(negedge clk);
        check("next_ready1", 64'(rd_ready1), 64'(1));
        check("next_value1", rd_value1, 64'h1234);
        check("idle_cdb_ready2", 64'(rd_ready2), 64'(0));
        check("idle_cdb_value2", rd_value2, 64'h0);
        next_cycle();
        @(negedge clk);
        check("idle_ignored_ready2", 64'(rd_ready2), 64'(0));
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            cdb(TAG_W'(i), 64'h500 + 64'(i), 1'b0, 64'h0);
        end
        wait_empty(10);

        // Reset with five finished entries retires nothing
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            alloc(RD_W'(i));
        end
        for (int i = 4; i >= 0; i--) begin
            next_cycle();
            cdb(TAG_W'(i), 64'h900 + 64'(i), 1'b0, 64'h0);
        end
        do_reset();

        // Random allocation/writeback traffic including rd=0
        for (int c = 0; c < 300; c++) begin
            next_cycle();
            if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, pending.size() - 1);
                t = pending[k];
                pending.delete(k);
                cdb(t, {$urandom, $urandom}, 1'b0, 64'h0);
            end
            if (alloc_ready && $urandom_range(0, 2) != 0) begin
                pending.push_back(model_tail);
                alloc(RD_W'($urandom_range(0, 31)));
            end
        end
        while (pending.size() > 0) begin
            next_cycle();
            t = pending.pop_front();
            cdb(t, {$urandom, $urandom}, 1'b0, 64'h0);
        end
        wait_empty(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, 16, number of entries; power of two, at least 4.
REQ-002 Parameter COMMIT_WIDTH, 2, maximum retirements per cycle; 1 to 4.
REQ-003 Parameter DATA_W, 64, result and PC width.
REQ-004 Parameter TAG_W, $clog2(DEPTH), width of the entry tag.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 alloc_valid  in  1  dispatch requests one entry.
REQ-008 alloc_rd  in  5  destination architectural register.
REQ-009 alloc_pc  in  DATA_W  PC of the instruction.
REQ-010 alloc_ready  out  1  an entry is free.
REQ-011 alloc_tag  out  TAG_W  tag given to an accepted allocation (current tail index).
REQ-012 cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target  in  1/TAG_W/DATA_W/1/DATA_W  writeback broadcast.
REQ-013 rd_tag1, rd_tag2  in  TAG_W  operand lookup tags.
REQ-014 rd_ready1, rd_ready2  out  1  looked-up entry has its result.
REQ-015 rd_value1, rd_value2  out  DATA_W  result of the looked-up entry.
REQ-016 commit_valid  out  COMMIT_WIDTH  per-slot retire strobe; slot 0 is the oldest.
REQ-017 commit_rd, commit_value  out  COMMIT_WIDTH*5 / COMMIT_WIDTH*DATA_W  retiring destination register and value.
REQ-018 flush, flush_pc  out  1/DATA_W  mispredict redirect.
REQ-019 count  out  TAG_W+1  occupied entries; empty  out  1  count==0.

Function
REQ-020 Circular buffer with head and tail pointers plus wrap bits; pointers wrap from DEPTH-1 to 0.
REQ-021 alloc_ready = (count < DEPTH) && !flush; it depends only on registered state, and a same-cycle commit does not free a slot.
REQ-022 alloc_valid && alloc_ready: entry[tail] gets busy=1, done=0, rd, pc; tail advances at the edge.
REQ-023 cdb_valid to a busy entry: that entry gets done=1 plus value, mispredict and target at the edge. A CDB write to a non-busy entry is ignored.
REQ-024 Commit is combinational from state. Slot i is valid iff entries head..head+i are all busy and done, and none of the older slots has mispredict=1. Up to COMMIT_WIDTH slots retire per cycle, and head advances by the number retired.
REQ-025 A retiring entry with mispredict=1 is the last slot that cycle. In that cycle flush=1 and flush_pc=its target. At the edge all entries are cleared, head=tail, count=0, and any alloc in that cycle is dropped.
REQ-026 rd ports are combinational. ready = busy && done; value = stored result. For a non-busy entry, ready=0 and value=0.
REQ-027 count updates as count + accepted alloc - retired; alloc and commit in the same cycle are legal.
REQ-028 Entries with rd=0 retire normally with commit_rd=0; the register file ignores them.

Reset
REQ-029 While reset is high: head=tail=count=0, all busy/done/mispredict bits are 0, CDB and alloc are ignored.
REQ-030 Output values during and after reset: alloc_ready=1, alloc_tag=0, commit_valid=0, flush=0, empty=1, rd_ready=0.
REQ-031 Reset asserted mid-operation discards all in-flight entries with no commit or flush.

Configuration
REQ-032 With ROB_CDB_BYPASS_EN defined: if cdb_valid && cdb_tag==rd_tagN and that entry is busy, rd_readyN=1 and rd_valueN=cdb_value in the same cycle.
REQ-033 Without ROB_CDB_BYPASS_EN: the CDB result is visible on the rd ports from the next cycle.

Structure
REQ-034 The rob_entry typedef (busy, done, mispredict, rd, pc, value, target) and ROB_SIZE/COMMIT_WIDTH defaults live in the shared consts package.
REQ-035 The in-order priority scan is a sub-module named rob_commit_select: it takes DEPTH done/mispredict vectors and head, and outputs per-slot valid and index.

Verification
REQ-036 Reset, then 16 allocs with no CDB -> tags 0..15; count=16; alloc_ready=0 on the 17th cycle.
REQ-037 Allocate tags 0,1,2; CDB tag1 value 0xAA, then tag0 value 0x55 -> no commit after tag1 alone; after tag0, slot0=(0x55), slot1=(0xAA) in one cycle; head=2.
REQ-038 Full buffer, head entry done -> commit slot0 and alloc_ready=0 that cycle; alloc accepted next cycle with tag wrapped to 0.
REQ-039 Allocate 4; CDB tag0 mispredict target 0x80000100, tag1 done -> only slot0 retires, flush=1, flush_pc=0x80000100; next cycle count=0, empty=1.
REQ-040 CDB tag3 value 0x1234 with rd_tag1=3 in the same cycle -> rd_ready1=1 that cycle with the macro, next cycle without it.
REQ-041 Reset asserted with 5 done entries -> commit_valid=0; count=0 on the following cycle.
